dbg_host: RTL and testbench

- Initiator end of the dbgu32 debug link: converts parallel debug requests into the dbgu32 byte protocol and parses the replies.
- Used by a supervisor FPGA or a self-test harness to drive a target SoC's debug UART.
- Sits between a request source and an external byte-level UART TX/RX pair.
- Does not serialise bits itself.

---
 rtl/dbg_host_if.sv | 35 +++
 rtl/dbg_host.sv | 145 ++++++++++++++
 tb/tb_dbg_host.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dbg_host_if.sv
// dbg_host_if: bundle of the request/response, UART byte and status signals
// of the dbgu32 initiator.
//   slave  : seen from dbg_host (takes requests and rx bytes, drives tx bytes)
//   master : seen from the request source / UART pair / testbench
//   req_*  : request handshake, op/address/write data
//   rsp_*  : completion pulse, read data, error flag
//   tx_*   : byte stream to the UART transmitter (valid/ready)
//   rx_*   : byte strobe from the UART receiver
//   busy   : block is not idle
interface dbg_host_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_adr;
  logic [31:0] req_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        busy;

  modport slave (
    input  req_valid, req_op, req_adr, req_data, tx_ready, rx_data, rx_valid,
    output req_ready, rsp_valid, rsp_data, rsp_err, tx_data, tx_valid, busy
  );

  modport master (
    output req_valid, req_op, req_adr, req_data, tx_ready, rx_data, rx_valid,
    input  req_ready, rsp_valid, rsp_data, rsp_err, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/dbg_host.sv
// dbg_host: initiator end of the dbgu32 debug link. Turns one parallel
// request into a command frame (cmd byte, optional address and data words,
// LSB first), then collects the reply: 4 data bytes for a read, a single
// ACK byte (0x06) otherwise. Replies are guarded by an inter-byte timeout.
// Ports:
//   clk     : system clock
//   n_reset : asynchronous active-low reset
//   bus     : dbg_host_if.slave (request, response, tx/rx bytes, busy)
module dbg_host #(
  parameter int unsigned TIMEOUT_CYCLES = 16_000
) (
  input  logic       clk,
  input  logic       n_reset,
  dbg_host_if.slave  bus
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_ADR  = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]    state_q, state_d;
  logic [2:0]    op_q, op_d;
  logic [31:0]   adr_q, adr_d;
  logic [31:0]   data_q, data_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [7:0]    tx_byte;
  logic          op_ok;

  assign op_ok = (bus.req_op >= 3'd1) && (bus.req_op <= 3'd5);

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    adr_d      = adr_q;
    data_d     = data_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      S_IDLE: if (bus.req_valid) begin
        op_d       = bus.req_op;
        adr_d      = bus.req_adr;
        data_d     = bus.req_data;
        idx_d      = 2'd0;
        rsp_data_d = 32'h0;
        rsp_err_d  = 1'b0;
        if (op_ok) state_d = S_CMD;
        else begin
          // invalid op: report immediately, nothing goes on the wire
          rsp_err_d = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_CMD: if (bus.tx_ready) begin
        cnt_d   = '0;
        state_d = (op_q == 3'd1 || op_q == 3'd2) ? S_ADR : S_WAIT;
      end
      S_ADR: if (bus.tx_ready) begin
        // idx wraps to 0 after byte 3, ready for the next phase
        idx_d = idx_q + 2'd1;
        cnt_d = '0;
        if (idx_q == 2'd3) state_d = (op_q == 3'd1) ? S_DATA : S_WAIT;
      end
      S_DATA: if (bus.tx_ready) begin
        idx_d = idx_q + 2'd1;
        cnt_d = '0;
        if (idx_q == 2'd3) state_d = S_WAIT;
      end
      S_WAIT: begin
        // a byte arriving in the last timeout cycle still counts
        if (bus.rx_valid) begin
          cnt_d = '0;
          if (op_q == 3'd2) begin
            rsp_data_d = {bus.rx_data, rsp_data_q[31:8]};
            idx_d      = idx_q + 2'd1;
            if (idx_q == 2'd3) state_d = S_DONE;
          end else begin
            rsp_err_d = (bus.rx_data != 8'h06);
            state_d   = S_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          rsp_err_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q    <= S_IDLE;
      op_q       <= 3'd0;
      adr_q      <= 32'h0;
      data_q     <= 32'h0;
      idx_q      <= 2'd0;
      cnt_q      <= '0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      adr_q      <= adr_d;
      data_q     <= data_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    case (state_q)
      S_CMD:   tx_byte = {5'b0, op_q};
      S_ADR:   tx_byte = adr_q[{idx_q, 3'b000} +: 8];
      S_DATA:  tx_byte = data_q[{idx_q, 3'b000} +: 8];
      default: tx_byte = 8'h00;
    endcase
  end

  // req_ready is gated by n_reset so it reads 0 while reset is held,
  // even though the state register already sits in IDLE.
  assign bus.req_ready = n_reset && (state_q == S_IDLE);
  assign bus.tx_valid  = (state_q == S_CMD) || (state_q == S_ADR) || (state_q == S_DATA);
  assign bus.tx_data   = tx_byte;
  assign bus.rsp_valid = (state_q == S_DONE);
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_dbg_host.sv
// tb_dbg_host: randomized and directed stimulus for dbg_host, checked every
// cycle against a transaction-level model (byte queue out, reply count in,
// idle-cycle budget), plus literal expectations for the directed cases.
module tb_dbg_host;
  localparam int T = 20;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  dbg_host_if bus();

  dbg_host #(.TIMEOUT_CYCLES(T)) dut (.clk(clk), .n_reset(n_reset), .bus(bus));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef enum int {M_IDLE, M_TX, M_RX, M_DONE} mph_t;
  mph_t        ph = M_IDLE;
  logic [7:0]  txq[$];
  int          need, idle;
  bit          is_rd;
  logic [31:0] m_data = 32'h0;
  logic        m_err = 1'b0;

  logic [7:0]  txlog[$];
  logic [7:0]  rq[$];
  int          gq[$];
  int          acc_cyc, rsp_cyc, lastrx_cyc;
  logic [31:0] r_data;
  logic        r_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    ph = M_IDLE; txq.delete(); m_data = 32'h0; m_err = 1'b0; need = 0; idle = 0;
  endtask

  // advance the model by one clock using the inputs presented this cycle
  task automatic model_step();
    logic [2:0] op;
    if (!n_reset) begin model_reset(); return; end
    case (ph)
      M_IDLE: if (bus.req_valid) begin
        op = bus.req_op; acc_cyc = cyc; m_data = 32'h0; m_err = 1'b0;
        if (op >= 3'd1 && op <= 3'd5) begin
          txq.delete();
          txq.push_back({5'b0, op});
          if (op <= 3'd2) for (int i = 0; i < 4; i++) txq.push_back(bus.req_adr[8*i +: 8]);
          if (op == 3'd1) for (int i = 0; i < 4; i++) txq.push_back(bus.req_data[8*i +: 8]);
          is_rd = (op == 3'd2);
          need  = is_rd ? 4 : 1;
          ph    = M_TX;
        end else begin
          m_err = 1'b1; ph = M_DONE;
        end
      end
      M_TX: if (bus.tx_ready) begin
        void'(txq.pop_front());
        if (txq.size() == 0) begin ph = M_RX; idle = 0; end
      end
      M_RX: if (bus.rx_valid) begin
        idle = 0; lastrx_cyc = cyc;
        if (is_rd) begin
          m_data = {bus.rx_data, m_data[31:8]};
          need--;
          if (need == 0) ph = M_DONE;
        end else begin
          m_err = (bus.rx_data != 8'h06); ph = M_DONE;
        end
      end else begin
        idle++;
        if (idle == T) begin m_err = 1'b1; ph = M_DONE; end
      end
      M_DONE: ph = M_IDLE;
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic compare();
    chk("req_ready", bus.req_ready, n_reset && ph == M_IDLE);
    chk("busy", bus.busy, ph != M_IDLE);
    chk("tx_valid", bus.tx_valid, ph == M_TX);
    if (ph == M_TX) chk("tx_data", bus.tx_data, txq[0]);
    if (!n_reset) chk("tx_data_rst", bus.tx_data, 0);
    chk("rsp_valid", bus.rsp_valid, ph == M_DONE);
    chk("rsp_data", bus.rsp_data, m_data);
    chk("rsp_err", bus.rsp_err, m_err);
  endtask

  task automatic tick();
    if (bus.tx_valid && bus.tx_ready) txlog.push_back(bus.tx_data);
    model_step();
    @(negedge clk);
    if (ph == M_DONE) begin rsp_cyc = cyc; r_data = m_data; r_err = m_err; end
    compare();
  endtask

  // one transaction; reply bytes in rq, idle gap before each in gq
  // txmode: 0 always ready, 1 toggling, 2 random
  task automatic run(input logic [2:0] op, input logic [31:0] adr, input logic [31:0] dat,
                     input int txmode, input bit stray);
    int budget = 0;
    int ri = 0;
    int g = 0;
    bit accepted = 0;
    mph_t pre;
    txlog.delete();
    repeat ($urandom_range(0, 2)) begin
      bus.rx_valid = stray ? 1'($urandom) : 1'b0; bus.rx_data = 8'($urandom);
      tick();
    end
    bus.req_op = op; bus.req_adr = adr; bus.req_data = dat; bus.req_valid = 1'b1;
    while (budget < 400) begin
      case (txmode)
        0:       bus.tx_ready = 1'b1;
        1:       bus.tx_ready = 1'(cyc % 2);
        default: bus.tx_ready = 1'($urandom);
      endcase
      bus.rx_valid = 1'b0;
      if (ph == M_RX && ri < rq.size()) begin
        if (g >= gq[ri]) begin
          bus.rx_valid = 1'b1; bus.rx_data = rq[ri]; ri++; g = 0;
        end else g++;
      end else if (stray && ph != M_RX) begin
        bus.rx_valid = 1'($urandom); bus.rx_data = 8'($urandom);
      end
      pre = ph;
      tick();
      if (pre == M_IDLE && bus.req_valid) begin
        accepted = 1;
        bus.req_valid = 1'b0;
        bus.req_op = 3'($urandom); bus.req_adr = $urandom; bus.req_data = $urandom;
      end
      if (accepted && ph == M_IDLE) break;
      budget++;
    end
    if (budget >= 400) chk("txn_budget", 1, 0);
    bus.rx_valid = 1'b0;
  endtask

  logic [7:0] exp_wr[9];
  logic [7:0] exp_rd[5];

  initial begin
    bus.req_valid = 0; bus.req_op = 0; bus.req_adr = 0; bus.req_data = 0;
    bus.tx_ready = 0; bus.rx_valid = 0; bus.rx_data = 0;
    exp_wr = '{8'h01, 8'h10, 8'h00, 8'h02, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_rd = '{8'h02, 8'h18, 8'h00, 8'h01, 8'h00};

    // reset state, then release
    bus.req_valid = 1'b1; bus.req_op = 3'd1;
    repeat (3) tick();
    bus.req_valid = 1'b0;
    n_reset = 1'b1;
    tick();
    chk("ready_after_release", bus.req_ready, 1);

    // write, no backpressure
    rq = '{8'h06}; gq = '{0};
    run(3'd1, 32'h0002_0010, 32'hDEAD_BEEF, 0, 0);
    chk("wr_nbytes", txlog.size(), 9);
    for (int i = 0; i < 9 && i < txlog.size(); i++) chk("wr_byte", txlog[i], exp_wr[i]);
    chk("wr_err", r_err, 0);

    // read with toggling tx_ready
    rq = '{8'h78, 8'h56, 8'h34, 8'h12}; gq = '{0, 1, 0, 2};
    run(3'd2, 32'h0001_0018, 32'h0, 1, 0);
    chk("rd_nbytes", txlog.size(), 5);
    for (int i = 0; i < 5 && i < txlog.size(); i++) chk("rd_byte", txlog[i], exp_rd[i]);
    chk("rd_data", r_data, 32'h1234_5678);
    chk("rd_err", r_err, 0);

    // control op with bad ACK, then stray bytes and a good op 4
    rq = '{8'h15}; gq = '{0};
    run(3'd3, 32'h0, 32'h0, 0, 0);
    chk("run_nbytes", txlog.size(), 1);
    if (txlog.size() > 0) chk("run_byte", txlog[0], 8'h03);
    chk("run_err", r_err, 1);
    rq = '{8'h06}; gq = '{1};
    run(3'd4, 32'h0, 32'h0, 2, 1);
    chk("halt_err", r_err, 0);

    // timeout after 2 of 4 read bytes
    rq = '{8'h11, 8'h22}; gq = '{0, 3};
    run(3'd2, 32'h0000_0040, 32'h0, 0, 0);
    chk("to_err", r_err, 1);
    chk("to_partial", r_data, 32'h2211_0000);
    chk("to_latency", rsp_cyc - (lastrx_cyc + 1), 20);

    // byte in the last allowed idle cycle is accepted
    rq = '{8'hA1, 8'hB2, 8'hC3, 8'hD4}; gq = '{19, 19, 0, 19};
    run(3'd2, 32'h0000_0044, 32'h0, 0, 0);
    chk("bnd_err", r_err, 0);
    chk("bnd_data", r_data, 32'hD4C3_B2A1);
    // one idle cycle more times out
    rq = '{8'h06}; gq = '{20};
    run(3'd5, 32'h0, 32'h0, 0, 0);
    chk("bnd_to_err", r_err, 1);

    // invalid ops
    for (int k = 0; k < 3; k++) begin
      rq.delete(); gq.delete();
      run((k == 0) ? 3'd7 : (k == 1) ? 3'd0 : 3'd6, 32'h0, 32'h0, 0, 1);
      chk("inv_nbytes", txlog.size(), 0);
      chk("inv_err", r_err, 1);
      chk("inv_latency", rsp_cyc - acc_cyc, 1);
    end

    // randomized transactions
    for (int n = 0; n < 40; n++) begin
      logic [2:0] op;
      op = 3'($urandom_range(0, 7));
      rq.delete(); gq.delete();
      for (int b = 0; b < 4; b++) begin
        rq.push_back((op != 3'd2 && $urandom_range(0, 2) != 0) ? 8'h06 : 8'($urandom));
        gq.push_back(($urandom_range(0, 9) == 0) ? 21 : $urandom_range(0, 4));
      end
      run(op, $urandom, $urandom, 2, 1'($urandom));
    end

    // reset in the middle of the address bytes
    bus.tx_ready = 1'b1; bus.req_op = 3'd1; bus.req_adr = 32'h55AA_0000;
    bus.req_data = 32'h1; bus.req_valid = 1'b1;
    tick();
    bus.req_valid = 1'b0;
    tick(); tick();
    chk("abort_in_tx", bus.tx_valid, 1);
    #2 n_reset = 1'b0;
    #1;
    chk("abort_tx_valid", bus.tx_valid, 0);
    chk("abort_tx_data", bus.tx_data, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ready", bus.req_ready, 0);
    chk("abort_rsp_valid", bus.rsp_valid, 0);
    chk("abort_rsp_err", bus.rsp_err, 0);
    model_reset();
    tick(); tick();
    n_reset = 1'b1;
    tick();
    chk("abort_ready_after", bus.req_ready, 1);
    rq = '{8'h06}; gq = '{2};
    run(3'd1, 32'h0002_0010, 32'hDEAD_BEEF, 0, 0);
    chk("post_abort_nbytes", txlog.size(), 9);
    for (int i = 0; i < 9 && i < txlog.size(); i++) chk("post_abort_byte", txlog[i], exp_wr[i]);
    chk("post_abort_err", r_err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
